// File: rtl/quad_sqrt.sv
// quad_sqrt: iterative restoring integer square root, one root bit per cycle, valid/ready on both sides
module quad_sqrt #(
    parameter int IN_W = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IN_W/2-1:0] root,
    output logic [IN_W/2:0]   rem
);
    localparam int OUT_W = IN_W / 2;
    localparam int CW = $clog2(OUT_W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic [OUT_W+1:0] r_q, r_d, r_sh, t;
    logic [OUT_W-1:0] q_q, q_d, root_q, root_d;
    logic [OUT_W:0]   rem_q, rem_d;
    logic             ge;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign root      = root_q;
    assign rem       = rem_q;
    always_comb begin
        r_sh    = {r_q[OUT_W-1:0], x_q[IN_W-1 -: 2]};
        t       = {q_q, 2'b01};
        ge      = r_sh >= t;
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        r_d     = r_q;
        q_d     = q_q;
        root_d  = root_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = x;
                r_d     = '0;
                q_d     = '0;
                cnt_d   = CW'(OUT_W - 1);
                state_d = CALC;
            end
            CALC: begin
                x_d   = x_q << 2;
                r_d   = ge ? r_sh - t : r_sh;
                q_d   = {q_q[OUT_W-2:0], ge};
                cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    root_d  = q_d;
                    rem_d   = r_d[OUT_W:0];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            r_q     <= r_d;
            q_q     <= q_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end
endmodule
